// File: rtl/rtc_set_ctrl.sv
// rtc_set_ctrl: time-set controller for the BCD real-time clock chain.
// Two debounced buttons step the user through hour and minute editing on a
// shadow copy of the time; a one-cycle load pulse then presets the counters.
module rtc_set_ctrl #(
    parameter int unsigned TIMEOUT = 30
) (
    input  logic       clk_1hz,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [3:0] cur_hrm,
    input  logic [3:0] cur_hrl,
    input  logic [3:0] cur_minm,
    input  logic [3:0] cur_minl,
    output logic       load,
    output logic [3:0] set_hrm,
    output logic [3:0] set_hrl,
    output logic [3:0] set_minm,
    output logic [3:0] set_minl,
    output logic       run_en,
    output logic [1:0] edit_field,
    output logic       blink
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        COMMIT  = 2'd3
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [3:0] hrm_q, hrl_q, minm_q, minl_q;
    logic [3:0] hrm_d, hrl_d, minm_d, minl_d;
    logic [7:0] tmo_q, tmo_d;
    logic       blink_q, blink_d;
    logic       mode_prev_q, inc_prev_q;
    logic       mode_ev, inc_ev;
    logic [3:0] hr_inc_m, hr_inc_l, min_inc_m, min_inc_l;

    // Rising-edge detection on the debounced button levels
    always_comb begin
        mode_ev = btn_mode & ~mode_prev_q;
        inc_ev  = btn_inc & ~inc_prev_q;
    end

    // BCD hour increment 00..23; any out-of-range shadow restarts at 00
    always_comb begin
        hr_inc_m = '0;
        hr_inc_l = '0;
        if ((hrm_q < 4'd2 && hrl_q <= 4'd9) || (hrm_q == 4'd2 && hrl_q <= 4'd3)) begin
            if (hrm_q == 4'd2 && hrl_q == 4'd3) begin
                hr_inc_m = '0;
                hr_inc_l = '0;
            end else if (hrl_q == 4'd9) begin
                hr_inc_m = hrm_q + 4'd1;
                hr_inc_l = '0;
            end else begin
                hr_inc_m = hrm_q;
                hr_inc_l = hrl_q + 4'd1;
            end
        end
    end

    // BCD minute increment 00..59; any out-of-range shadow restarts at 00
    always_comb begin
        min_inc_m = '0;
        min_inc_l = '0;
        if (minm_q <= 4'd5 && minl_q <= 4'd9) begin
            if (minm_q == 4'd5 && minl_q == 4'd9) begin
                min_inc_m = '0;
                min_inc_l = '0;
            end else if (minl_q == 4'd9) begin
                min_inc_m = minm_q + 4'd1;
                min_inc_l = '0;
            end else begin
                min_inc_m = minm_q;
                min_inc_l = minl_q + 4'd1;
            end
        end
    end

    // Next-state, shadow/timeout/blink update and Moore output decode
    always_comb begin
        state_d    = state_q;
        hrm_d      = hrm_q;
        hrl_d      = hrl_q;
        minm_d     = minm_q;
        minl_d     = minl_q;
        tmo_d      = tmo_q;
        blink_d    = 1'b0;
        load       = 1'b0;
        run_en     = 1'b0;
        edit_field = 2'b00;

        case (state_q)
            RUN: begin
                run_en = 1'b1;
                if (mode_ev) begin
                    hrm_d   = cur_hrm;
                    hrl_d   = cur_hrl;
                    minm_d  = cur_minm;
                    minl_d  = cur_minl;
                    tmo_d   = '0;
                    state_d = SET_HR;
                end
            end
            SET_HR: begin
                edit_field = 2'b01;
                blink_d    = ~blink_q;
                if (mode_ev) begin
                    tmo_d   = '0;
                    state_d = SET_MIN;
                end else if (inc_ev) begin
                    hrm_d = hr_inc_m;
                    hrl_d = hr_inc_l;
                    tmo_d = '0;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d   = '0;
                    blink_d = 1'b0;
                    state_d = RUN;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            SET_MIN: begin
                edit_field = 2'b10;
                blink_d    = ~blink_q;
                if (mode_ev) begin
                    tmo_d   = '0;
                    blink_d = 1'b0;
                    state_d = COMMIT;
                end else if (inc_ev) begin
                    minm_d = min_inc_m;
                    minl_d = min_inc_l;
                    tmo_d  = '0;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d   = '0;
                    blink_d = 1'b0;
                    state_d = RUN;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            COMMIT: begin
                load    = 1'b1;
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State, shadow, timeout, blink and button-history registers
    always_ff @(posedge clk_1hz) begin
        if (!rst) begin
            state_q     <= RUN;
            hrm_q       <= '0;
            hrl_q       <= '0;
            minm_q      <= '0;
            minl_q      <= '0;
            tmo_q       <= '0;
            blink_q     <= 1'b0;
            mode_prev_q <= 1'b1;
            inc_prev_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            hrm_q       <= hrm_d;
            hrl_q       <= hrl_d;
            minm_q      <= minm_d;
            minl_q      <= minl_d;
            tmo_q       <= tmo_d;
            blink_q     <= blink_d;
            mode_prev_q <= btn_mode;
            inc_prev_q  <= btn_inc;
        end
    end

    // Shadow digits and blink are visible directly from their registers
    always_comb begin
        set_hrm  = hrm_q;
        set_hrl  = hrl_q;
        set_minm = minm_q;
        set_minl = minl_q;
        blink    = blink_q;
    end

endmodule

// File: tb/tb_rtc_set_ctrl.sv
// Testbench for rtc_set_ctrl: directed test-plan scenarios followed by random
// button/time stimulus, all checked every cycle against a behavioural model.
module tb_rtc_set_ctrl;

    localparam int TMO = 30;

    logic       clk_1hz = 1'b0;
    logic       rst = 1'b0;
    logic       btn_mode = 1'b1;
    logic       btn_inc = 1'b0;
    logic [3:0] cur_hrm = '0, cur_hrl = '0, cur_minm = '0, cur_minl = '0;
    logic       load, run_en, blink;
    logic [3:0] set_hrm, set_hrl, set_minm, set_minl;
    logic [1:0] edit_field;

    int compared = 0;
    int mismatched = 0;

    rtc_set_ctrl #(.TIMEOUT(TMO)) dut (
        .clk_1hz(clk_1hz), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .cur_hrm(cur_hrm), .cur_hrl(cur_hrl), .cur_minm(cur_minm), .cur_minl(cur_minl),
        .load(load), .set_hrm(set_hrm), .set_hrl(set_hrl), .set_minm(set_minm),
        .set_minl(set_minl), .run_en(run_en), .edit_field(edit_field), .blink(blink)
    );

    always #5 clk_1hz = ~clk_1hz;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 = running, 1 = editing hours, 2 = editing minutes, 3 = loading
    int m_mode = 0;
    int m_h1 = 0, m_h0 = 0, m_m1 = 0, m_m0 = 0;
    int m_idle = 0;
    bit m_blink = 0;
    bit m_mprev = 1, m_iprev = 1;
    bit m_valid = 0;

    function automatic int wrap_inc(input int tens, input int units, input int modulus);
        int v;
        v = tens * 10 + units;
        if (tens > 9 || units > 9 || v >= modulus) return 0;
        return (v + 1) % modulus;
    endfunction

    always @(posedge clk_1hz) begin
        bit mev, iev;
        int v;
        if (!rst) begin
            m_mode = 0; m_h1 = 0; m_h0 = 0; m_m1 = 0; m_m0 = 0;
            m_idle = 0; m_blink = 0; m_mprev = 1; m_iprev = 1;
            m_valid = 1;
        end else begin
            mev = btn_mode && !m_mprev;
            iev = btn_inc && !m_iprev;
            m_mprev = btn_mode;
            m_iprev = btn_inc;
            case (m_mode)
                0: if (mev) begin
                    m_h1 = cur_hrm; m_h0 = cur_hrl; m_m1 = cur_minm; m_m0 = cur_minl;
                    m_idle = 0; m_blink = 0; m_mode = 1;
                end
                1, 2: begin
                    if (mev) begin
                        m_idle = 0;
                        m_mode = m_mode + 1;
                        m_blink = (m_mode == 2) ? !m_blink : 0;
                    end else if (iev) begin
                        if (m_mode == 1) begin
                            v = wrap_inc(m_h1, m_h0, 24); m_h1 = v / 10; m_h0 = v % 10;
                        end else begin
                            v = wrap_inc(m_m1, m_m0, 60); m_m1 = v / 10; m_m0 = v % 10;
                        end
                        m_idle = 0; m_blink = !m_blink;
                    end else if (m_idle == TMO - 1) begin
                        m_mode = 0; m_blink = 0;
                    end else begin
                        m_idle++; m_blink = !m_blink;
                    end
                end
                default: m_mode = 0;
            endcase
        end
    end

    // Compare every cycle once the model has seen a reset
    always @(negedge clk_1hz) begin
        if (m_valid) begin
            check("load", load, m_mode == 3);
            check("run_en", run_en, m_mode == 0);
            check("edit_field", edit_field, (m_mode == 1) ? 1 : (m_mode == 2) ? 2 : 0);
            check("blink", blink, m_blink);
            check("set", {set_hrm, set_hrl, set_minm, set_minl},
                  (m_h1 << 12) | (m_h0 << 8) | (m_m1 << 4) | m_m0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk_1hz);
        #2;
    endtask

    task automatic press_mode;
        btn_mode = 1'b1; tick; btn_mode = 1'b0; tick;
    endtask

    task automatic press_inc;
        btn_inc = 1'b1; tick; btn_inc = 1'b0; tick;
    endtask

    task automatic set_cur(input logic [15:0] t);
        {cur_hrm, cur_hrl, cur_minm, cur_minl} = t;
    endtask

    initial begin
        int hold;

        // Reset with btn_mode held through release: no edge
        tick; tick;
        check("rst_run_en", run_en, 1);
        check("rst_set", {set_hrm, set_hrl, set_minm, set_minl}, 16'h0000);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("held_edit", edit_field, 0);
            check("held_load", load, 0);
            check("held_run", run_en, 1);
        end
        btn_mode = 1'b0; tick;

        // 12:34 -> 15:36 edit and commit
        set_cur(16'h1234);
        btn_mode = 1'b1; tick;
        check("tp2_edit", edit_field, 1);
        check("tp2_run", run_en, 0);
        check("tp2_cap", {set_hrm, set_hrl, set_minm, set_minl}, 16'h1234);
        btn_mode = 1'b0; tick;
        repeat (3) press_inc;
        check("tp2_hr", {set_hrm, set_hrl, set_minm, set_minl}, 16'h1534);
        press_mode;
        check("tp2_edit_min", edit_field, 2);
        repeat (2) press_inc;
        check("tp2_min", {set_hrm, set_hrl, set_minm, set_minl}, 16'h1536);
        btn_mode = 1'b1; tick;
        check("tp2_load", load, 1);
        check("tp2_load_set", {set_hrm, set_hrl, set_minm, set_minl}, 16'h1536);
        check("tp2_load_run", run_en, 0);
        btn_mode = 1'b0; tick;
        check("tp2_load_end", load, 0);
        check("tp2_run_again", run_en, 1);
        check("tp2_keep", {set_hrm, set_hrl, set_minm, set_minl}, 16'h1536);

        // Wrap cases
        set_cur(16'h1909);
        press_mode; press_inc;
        check("hr19", {set_hrm, set_hrl}, 8'h20);
        press_mode; press_inc;
        check("min09", {set_minm, set_minl}, 8'h10);
        press_mode;
        set_cur(16'h2359);
        press_mode; press_inc;
        check("hr23", {set_hrm, set_hrl}, 8'h00);
        press_mode; press_inc;
        check("min59", {set_minm, set_minl}, 8'h00);

        // Simultaneous edges in minute edit: mode wins
        btn_mode = 1'b1; btn_inc = 1'b1; tick;
        check("simul_load", load, 1);
        check("simul_min", {set_minm, set_minl}, 8'h00);
        btn_mode = 1'b0; btn_inc = 1'b0; tick;

        // Timeout after 30 idle cycles
        set_cur(16'h0815);
        btn_mode = 1'b1; tick; btn_mode = 1'b0;
        repeat (29) tick;
        check("tmo_29", edit_field, 1);
        tick;
        check("tmo_30_edit", edit_field, 0);
        check("tmo_30_run", run_en, 1);
        check("tmo_30_load", load, 0);
        check("tmo_set", {set_hrm, set_hrl, set_minm, set_minl}, 16'h0815);

        // Press at cycle 29 restarts the count
        btn_mode = 1'b1; tick; btn_mode = 1'b0;
        repeat (28) tick;
        btn_inc = 1'b1; tick; btn_inc = 1'b0;
        tick;
        check("restart_30", edit_field, 1);
        repeat (28) tick;
        check("restart_58", edit_field, 1);
        tick;
        check("restart_59", edit_field, 0);
        check("restart_hr", {set_hrm, set_hrl}, 8'h09);

        // Reset during minute edit
        press_mode; press_mode;
        rst = 1'b0; tick;
        check("rstmid_edit", edit_field, 0);
        check("rstmid_load", load, 0);
        check("rstmid_set", {set_hrm, set_hrl, set_minm, set_minl}, 16'h0000);
        check("rstmid_blink", blink, 0);
        rst = 1'b1; tick;

        // Random phase
        for (int it = 0; it < 600; it++) begin
            hold = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 40))
                                               : int'($urandom_range(1, 3));
            btn_mode = ($urandom_range(0, 2) == 0);
            btn_inc  = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0)
                set_cur(16'($urandom));
            else
                set_cur({4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)),
                         4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))});
            rst = ($urandom_range(0, 80) != 0);
            tick;
            rst = 1'b1;
            repeat (hold - 1) tick;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
